// File: rtl/key_step_pkg.sv
// Shared state encoding and default 50 MHz timing for the key step pulser.
package key_step_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } kstate_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000; // 0.5 s
  localparam int unsigned DEF_REPEAT_PERIOD   = 12_500_000; // 0.25 s

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs; reset value selectable.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK50M,
  input  logic CLRb,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge CLK50M or negedge CLRb) begin
    if (!CLRb) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/key_step_pulser.sv
// Debounces a raw pushbutton into single-cycle STEP pulses on CLK50M,
// with optional hold-to-repeat. One shared counter serves every timed state.
module key_step_pulser
  import key_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic CLK50M,
  input  logic CLRb,
  input  logic KEY,
  input  logic EN,
  output logic STEP,
  output logic PRESSED,
  output logic REPEATING
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);

  logic          w_key_s;
  logic          w_p;
  kstate_t       r_state;
  logic [CW-1:0] r_cnt;
  logic          r_step;
  logic          r_pressed;
  logic          r_repeating;

  // Synchronizer resets to the released level so reset never looks like a press.
  sync_2ff #(.RST_VAL(logic'(KEY_ACTIVE_LOW))) u_sync (
    .CLK50M (CLK50M),
    .CLRb   (CLRb),
    .d      (KEY),
    .q      (w_key_s)
  );

  assign w_p = KEY_ACTIVE_LOW ? ~w_key_s : w_key_s;

  always_ff @(posedge CLK50M or negedge CLRb) begin
    if (!CLRb) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_step      <= 1'b0;
      r_pressed   <= 1'b0;
      r_repeating <= 1'b0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_p) r_state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!w_p) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state   <= HELD;
            r_cnt     <= '0;
            r_step    <= EN;
            r_pressed <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        HELD: begin
          if (!w_p) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= '0;
          end else if (REPEAT_EN && r_cnt == RD_LAST) begin
            r_state     <= REPEAT;
            r_cnt       <= '0;
            r_step      <= EN;
            r_repeating <= 1'b1;
          end else if (r_cnt != RD_LAST) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        REPEAT: begin
          // Release beats a coincident period expiry: no pulse on the way out.
          if (!w_p) begin
            r_state     <= RELEASE_WAIT;
            r_cnt       <= '0;
            r_repeating <= 1'b0;
          end else if (r_cnt == RP_LAST) begin
            r_cnt  <= '0;
            r_step <= EN;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (w_p) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pressed <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_pressed   <= 1'b0;
          r_repeating <= 1'b0;
        end
      endcase
    end
  end

  assign STEP      = r_step;
  assign PRESSED   = r_pressed;
  assign REPEATING = r_repeating;

endmodule

// File: tb/tb_key_step_pulser.sv
// Directed table-driven bench for key_step_pulser with short debounce/repeat timings.
module tb_key_step_pulser;

  logic CLK50M = 1'b0;
  logic CLRb   = 1'b0;
  logic KEY    = 1'b0;
  logic EN     = 1'b1;
  logic STEP, PRESSED, REPEATING;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic key;
    logic en;
    logic step;
    logic pressed;
    logic rep;
  } vec_t;

  vec_t vq[$];

  key_step_pulser #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .REPEAT_EN       (1'b1),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .CLK50M    (CLK50M),
    .CLRb      (CLRb),
    .KEY       (KEY),
    .EN        (EN),
    .STEP      (STEP),
    .PRESSED   (PRESSED),
    .REPEATING (REPEATING)
  );

  always #5 CLK50M = ~CLK50M;

  task automatic tick();
    @(posedge CLK50M);
    #1;
  endtask

  task automatic check(input string nm, input int idx, input logic [2:0] exp);
    checks++;
    if ({STEP, PRESSED, REPEATING} !== exp) begin
      errors++;
      $display("FAIL %s[%0d] step/pressed/repeating got %b want %b",
               nm, idx, {STEP, PRESSED, REPEATING}, exp);
    end
  endtask

  task automatic add(input logic key, input logic en, input logic step,
                     input logic pressed, input logic rep);
    vec_t v;
    v.key = key; v.en = en; v.step = step; v.pressed = pressed; v.rep = rep;
    vq.push_back(v);
  endtask

  // Entry c drives KEY/EN ahead of edge c, then checks outputs just after it.
  task automatic run_seg(input string nm);
    for (int i = 0; i < vq.size(); i++) begin
      KEY = vq[i].key;
      EN  = vq[i].en;
      tick();
      check(nm, i + 1, {vq[i].step, vq[i].pressed, vq[i].rep});
    end
    vq.delete();
  endtask

  initial begin
    // Reset held with key pressed: everything stays quiet.
    CLRb = 1'b0; KEY = 1'b0; EN = 1'b1;
    #2 check("rst_async", 0, 3'b000);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("rst_hold", i, 3'b000);
    end
    KEY = 1'b1;
    tick();
    CLRb = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("rst_idle", i, 3'b000);
    end

    // Clean press held 40 cycles: accept at 7, first repeat at 17, then every 3.
    for (int c = 1; c <= 50; c++)
      add(c <= 40 ? 1'b0 : 1'b1, 1'b1,
          (c == 7) || (c >= 17 && c <= 41 && (c - 17) % 3 == 0),
          (c >= 7 && c <= 46),
          (c >= 17 && c <= 42));
    run_seg("hold");

    // Press bounce: 3 low, 2 high, five times; never reaches the debounce count.
    for (int r = 0; r < 5; r++)
      for (int j = 0; j < 5; j++)
        add(j < 3 ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_seg("bounce");

    // Release glitch at 12..13 inside hold: no extra step, repeat delay restarts at 16.
    for (int c = 1; c <= 40; c++)
      add((c <= 30 && c != 12 && c != 13) ? 1'b0 : 1'b1, 1'b1,
          (c == 7) || (c == 26) || (c == 29) || (c == 32),
          (c >= 7 && c <= 36),
          (c >= 26 && c <= 32));
    run_seg("rel_glitch");

    // EN low through the accept and first repeat: state still advances, pulses masked.
    for (int c = 1; c <= 23; c++)
      add(1'b0, (c >= 19), (c == 20) || (c == 23), (c >= 7), (c >= 17));
    run_seg("en_mask");

    // Asynchronous reset while STEP is high in REPEAT.
    #2 CLRb = 1'b0;
    #1 check("rst_mid", 0, 3'b000);
    tick();
    check("rst_mid", 1, 3'b000);
    KEY = 1'b1;
    tick();
    check("rst_mid", 2, 3'b000);
    CLRb = 1'b1;
    for (int c = 1; c <= 4; c++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) add(1'b0, 1'b1, (c == 7), (c >= 7), 1'b0);
    run_seg("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
